// File: rtl/handshake_fifo_nontransparent.sv
// Elastic handshake FIFO with a registered output and a registered ready.
// Breaks both the valid/data path and the ready path of the channel.
module handshake_fifo_nontransparent #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 4,
  localparam int CW = $clog2(NUM_SLOTS + 1),
  localparam int PW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic [DATA_WIDTH-1:0] outs,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CW-1:0]         occupancy
);

  localparam logic [PW-1:0] LAST = PW'(NUM_SLOTS - 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_SLOTS);

  logic [DATA_WIDTH-1:0] mem [NUM_SLOTS];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  push;
  logic                  pop;

  // Depth need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PW-1:0] next_ptr(
    input logic [PW-1:0] p
  );
    return (p == LAST) ? '0 : p + PW'(1);
  endfunction

  assign ins_ready  = rst & (count != FULL);
  assign outs_valid = (count != '0);
  assign outs       = mem[rd_ptr];
  assign occupancy  = count;

  assign push = ins_valid & ins_ready;
  assign pop  = outs_valid & outs_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ins;
  end

  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst)
    (count <= FULL) && !((count == FULL) && push)
  );

  a_no_underflow: assert property (
    @(posedge clk) disable iff (!rst)
    !((count == '0) && pop)
  );

endmodule

// File: tb/tb_handshake_fifo_nontransparent.sv
// Random and directed scoreboard bench for the handshake FIFO.
// Runs a 4-slot and a 3-slot instance side by side on shared stimulus.
module tb_handshake_fifo_nontransparent;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        outs_ready;

  logic        ins_ready4, outs_valid4;
  logic [31:0] outs4;
  logic [2:0]  occ4;

  logic        ins_ready3, outs_valid3;
  logic [31:0] outs3;
  logic [1:0]  occ3;

  int checks = 0;
  int errors = 0;

  logic [31:0] q4[$];
  logic [31:0] q3[$];

  always #5 clk = ~clk;

  handshake_fifo_nontransparent #(
    .DATA_WIDTH(32),
    .NUM_SLOTS (4)
  ) dut4 (
    .clk       (clk),
    .rst       (rst),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready4),
    .outs      (outs4),
    .outs_valid(outs_valid4),
    .outs_ready(outs_ready),
    .occupancy (occ4)
  );

  handshake_fifo_nontransparent #(
    .DATA_WIDTH(32),
    .NUM_SLOTS (3)
  ) dut3 (
    .clk       (clk),
    .rst       (rst),
    .ins       (ins),
    .ins_valid (ins_valid),
    .ins_ready (ins_ready3),
    .outs      (outs3),
    .outs_valid(outs_valid3),
    .outs_ready(outs_ready),
    .occupancy (occ3)
  );

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference model: a token queue per instance, updated on each edge.
  always @(posedge clk) begin
    if (rst) begin
      bit v4, r4, v3, r3;
      v4 = q4.size() != 0;
      r4 = q4.size() != 4;
      v3 = q3.size() != 0;
      r3 = q3.size() != 3;
      if (v4 && outs_ready) void'(q4.pop_front());
      if (r4 && ins_valid)  q4.push_back(ins);
      if (v3 && outs_ready) void'(q3.pop_front());
      if (r3 && ins_valid)  q3.push_back(ins);
    end
  end

  // Monitor: compare DUT outputs against the model away from the edge.
  always @(negedge clk) begin
    chk("ready4", 32'(ins_ready4), 32'(rst && q4.size() != 4));
    chk("valid4", 32'(outs_valid4), 32'(q4.size() != 0));
    chk("occ4", 32'(occ4), 32'(q4.size()));
    if (outs_valid4 && q4.size() != 0)
      chk("data4", outs4, q4[0]);
    chk("ready3", 32'(ins_ready3), 32'(rst && q3.size() != 3));
    chk("valid3", 32'(outs_valid3), 32'(q3.size() != 0));
    chk("occ3", 32'(occ3), 32'(q3.size()));
    if (outs_valid3 && q3.size() != 0)
      chk("data3", outs3, q3[0]);
    chk("ptr3", 32'((dut3.rd_ptr < 2'd3) && (dut3.wr_ptr < 2'd3)), 32'd1);
  end

  initial begin
    rst        = 1'b0;
    ins        = '0;
    ins_valid  = 1'b0;
    outs_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;

    // Single token, consumer always ready.
    @(negedge clk);
    ins        = 32'h15;
    ins_valid  = 1'b1;
    outs_ready = 1'b1;
    @(negedge clk);
    ins_valid  = 1'b0;
    repeat (3) @(negedge clk);

    // Fill to full with a stalled consumer, then drain.
    outs_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      ins       = 32'(i);
      ins_valid = 1'b1;
    end
    repeat (2) @(negedge clk);
    outs_ready = 1'b1;
    repeat (6) @(negedge clk);
    ins_valid = 1'b0;
    repeat (6) @(negedge clk);

    // Steady stream, one token per cycle.
    for (int i = 0; i < 20; i++) begin
      ins       = 32'(i);
      ins_valid = 1'b1;
      @(negedge clk);
    end
    ins_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Random traffic on both valid and ready.
    for (int i = 0; i < 1000; i++) begin
      ins        = $urandom;
      ins_valid  = 1'($urandom_range(0, 1));
      outs_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    ins_valid  = 1'b0;
    outs_ready = 1'b1;
    repeat (6) @(negedge clk);

    // Asynchronous reset with two tokens held.
    outs_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      ins       = 32'h100 + 32'(i);
      ins_valid = 1'b1;
      @(negedge clk);
    end
    ins_valid = 1'b0;
    #2 rst = 1'b0;
    q4.delete();
    q3.delete();
    #1;
    chk("rst_valid4", 32'(outs_valid4), 32'd0);
    chk("rst_ready4", 32'(ins_ready4), 32'd0);
    chk("rst_occ4", 32'(occ4), 32'd0);
    chk("rst_valid3", 32'(outs_valid3), 32'd0);
    chk("rst_ready3", 32'(ins_ready3), 32'd0);
    chk("rst_occ3", 32'(occ3), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    ins       = 32'h2A;
    ins_valid = 1'b1;
    @(negedge clk);
    ins_valid  = 1'b0;
    chk("post_rst_head4", outs4, 32'h2A);
    chk("post_rst_head3", outs3, 32'h2A);
    outs_ready = 1'b1;
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/handshake_fifo_nontransparent.md
Name: handshake_fifo_nontransparent

Overview:
- Elastic FIFO buffer placed on a handshake channel, directly downstream of a constant or operator stage.
- Absorbs the producer's tokens and breaks both paths: the valid/data path (registered output) and the ready path (`ins_ready` does not depend on `outs_ready`).
- Decouples the constant stage from a stalling consumer so tokens are not lost or duplicated.
- Fully synchronous to one clock; asynchronous active-low reset.

Parameters:
- DATA_WIDTH, 32, width of the data token carried on `ins`/`outs`.
- NUM_SLOTS, 4, FIFO depth in tokens. Must be >= 2; need not be a power of 2.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted); deassertion is synchronous to `clk` upstream.
- ins  input  DATA_WIDTH  input token data.
- ins_valid  input  1  producer has a token on `ins`.
- ins_ready  output  1  FIFO can accept a token this cycle.
- outs  output  DATA_WIDTH  head-of-FIFO token data.
- outs_valid  output  1  FIFO holds at least one token.
- outs_ready  input  1  consumer accepts the head token this cycle.
- occupancy  output  clog2(NUM_SLOTS+1)  current token count (debug/perf observation).

Behaviour:
- **State:** storage array of NUM_SLOTS x DATA_WIDTH; `wr_ptr` and `rd_ptr` in range 0..NUM_SLOTS-1; `count` in range 0..NUM_SLOTS.
- **Reset (`rst` = 0, asynchronous):**
  - `wr_ptr`, `rd_ptr` and `count` go to 0.
  - `outs_valid` = 0, `ins_ready` = 0 (forced low while `rst` = 0), `occupancy` = 0.
  - Storage contents are not reset.
  - Reset asserted mid-operation discards all held tokens immediately, without waiting for a clock edge.
- **Signal derivation:**
  - `ins_ready` = `rst` & (`count` != NUM_SLOTS). Purely a function of registered state; no combinational path from `outs_ready`.
  - `outs_valid` = (`count` != 0). Registered-state-derived; no combinational path from `ins_valid`.
  - `outs` = storage[`rd_ptr`]. The value is don't-care when `outs_valid` = 0, and benches check `outs` only when `outs_valid` = 1.
  - `occupancy` = `count`.
- **Transfers:**
  - push = `ins_valid` & `ins_ready`
  - pop = `outs_valid` & `outs_ready`
- **On each rising edge (`rst` = 1):**
  - push only: storage[`wr_ptr`] <= `ins`; `wr_ptr` advances; `count` +1.
  - pop only: `rd_ptr` advances; `count` -1.
  - push and pop together: both pointers advance; `count` unchanged. Legal at any occupancy 1..NUM_SLOTS-1.
  - neither: no state change.
- **Pointer wrap:** a pointer advances to 0 after NUM_SLOTS-1, otherwise +1. Use an explicit compare, not modulo-2^n.
- **Latency:** a token pushed in cycle N is visible on `outs` with `outs_valid` = 1 in cycle N+1 at the earliest. There is no same-cycle bypass, even when empty.
- **Empty:** `outs_valid` = 0; a pop cannot occur; `outs_ready` is ignored.
- **Full:**
  - `ins_ready` = 0 and no push occurs, even if `outs_ready` = 1 in the same cycle.
  - `ins_ready` rises the cycle after a pop.
  - Full throughput is NUM_SLOTS-1 tokens in flight, or NUM_SLOTS with stalls.
- **Ordering:** strict FIFO; no token is dropped or duplicated.
- **Producer behaviour:** `ins` may change while `ins_valid` = 1 and `ins_ready` = 0. The FIFO samples `ins` only on push.
- **Assertions (simulation only):** `count` never exceeds NUM_SLOTS; `count` never underflows.

Test Plan:
1. Reset, then `ins` = 0x15 held, `ins_valid` = 1 for one cycle, `outs_ready` = 1 -> `outs_valid` rises exactly one cycle after the push with `outs` = 0x15; it drops the next cycle; `occupancy` goes 0 -> 1 -> 0.
2. `outs_ready` = 0; push 0x1, 0x2, 0x3, 0x4 on consecutive cycles (NUM_SLOTS = 4) -> `ins_ready` = 0 after the 4th push, `occupancy` = 4. A 5th value 0x5 held with `ins_valid` = 1 is not accepted. Then `outs_ready` = 1 -> outputs 0x1, 0x2, 0x3, 0x4 in order, and 0x5 is accepted the cycle after the first pop.
3. Steady stream with `ins_valid` = `outs_ready` = 1 for 20 cycles, values 0..19 -> after the 1-cycle fill, one token per cycle; `occupancy` stays 1; output sequence 0..19; pointers wrap cleanly.
4. NUM_SLOTS = 3 (non-power-of-2): push and pop 10 tokens with random `outs_ready` stalls -> order preserved; `rd_ptr` and `wr_ptr` never reach 3.
5. Fill to 2 tokens, assert `rst` = 0 between clock edges -> `outs_valid`, `ins_ready` and `occupancy` go to 0 without waiting for a clock edge. After release, the first new push (0x2A) appears as the first output.
6. Random `ins_valid`/`outs_ready` (50 %) over 1000 cycles, checked against a scoreboard -> no loss or duplication; `ins_ready` never depends on same-cycle `outs_ready`.
